// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath.
//   CALC_DATA_WIDTH : default operand width for ALU-stage blocks
//   div_state_e     : sequential divider control states
package calc_pkg;

   localparam int CALC_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_BUSY,
      DIV_DONE
   } div_state_e;

endpackage

// File: rtl/full_adder.sv
// Ripple-carry adder: sum = a + b + carry_in.
//   a, b      : DATA_WIDTH-bit addends
//   carry_in  : carry into bit 0
//   sum       : DATA_WIDTH-bit result
//   carry_out : carry out of the top bit
module full_adder #(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  carry_in,
   output logic [DATA_WIDTH-1:0] sum,
   output logic                  carry_out
);

   logic [DATA_WIDTH:0] c;

   assign c[0] = carry_in;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign carry_out = c[DATA_WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : request handshake; dividend/divisor sampled on it
//   out_valid/out_ready   : response handshake; results held until accepted
//   quotient, remainder   : floor(dividend/divisor), dividend mod divisor
//   div_by_zero           : divisor was zero (quotient all-ones, remainder=dividend)
module seq_divider
   import calc_pkg::*;
#(
   parameter int DATA_WIDTH = CALC_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  div_by_zero
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   div_state_e    state, state_nxt;
   logic [W-1:0]  q_reg;
   logic [W-1:0]  d_reg;
   logic [W-1:0]  rem;
   logic [CW-1:0] count;
   logic          dbz_reg;

   logic [W:0]    shifted;
   logic [W:0]    fa_sum;
   logic          fa_cout;
   logic          trial_ok;
   logic [W-1:0]  rem_nxt;

   // Next partial remainder candidate: bring down the next dividend bit.
   assign shifted = {rem, q_reg[W-1]};

   // shifted - d_reg computed as shifted + ~d_reg + 1; carry_out means no borrow.
   full_adder #(.DATA_WIDTH(W + 1)) u_trial (
      .a         (shifted),
      .b         (~{1'b0, d_reg}),
      .carry_in  (1'b1),
      .sum       (fa_sum),
      .carry_out (fa_cout)
   );

   // A successful trial always leaves sum[W]=0 because rem stays below the
   // divisor (and below 2^(W-1) shifted-in bits for a zero divisor); folding it
   // in keeps the whole adder result in the decision.
   assign trial_ok = fa_cout & ~fa_sum[W];

   always_comb begin
      state_nxt = state;
      rem_nxt   = shifted[W-1:0];
      if (trial_ok) rem_nxt = fa_sum[W-1:0];

      case (state)
         DIV_IDLE: if (in_valid && in_ready) state_nxt = DIV_BUSY;
         DIV_BUSY: if (count == LAST)        state_nxt = DIV_DONE;
         DIV_DONE: if (out_ready)            state_nxt = DIV_IDLE;
         default:                            state_nxt = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DIV_IDLE;
         q_reg   <= '0;
         d_reg   <= '0;
         rem     <= '0;
         count   <= '0;
         dbz_reg <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            DIV_IDLE: begin
               if (in_valid && in_ready) begin
                  q_reg   <= dividend;
                  d_reg   <= divisor;
                  rem     <= '0;
                  count   <= '0;
                  dbz_reg <= (divisor == '0);
               end
            end
            DIV_BUSY: begin
               // q_reg doubles as the dividend shifter and the quotient collector.
               rem   <= rem_nxt;
               q_reg <= {q_reg[W-2:0], trial_ok};
               count <= count + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready    = (state == DIV_IDLE) && !rst;
   assign out_valid   = (state == DIV_DONE);
   assign quotient    = q_reg;
   assign remainder   = rem;
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   seq_divider #(.DATA_WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           hs;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: latency on the rising out_valid, values on each response handshake.
   logic prev_v = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (out_valid && !prev_v) begin
            if (sb.size() == 0) chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
            else                chk("latency", cyc - sb[0].hs, W);
         end
         if (out_valid && out_ready && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient",    quotient,    e.q);
            chk("remainder",   remainder,   e.r);
            chk("div_by_zero", div_by_zero, e.z);
         end
         prev_v = out_valid;
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
      int n;
      exp_t e;
      @(posedge clk); #1;
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      e.q = q; e.r = r; e.z = z; e.hs = cyc;
      sb.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
   endtask

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
      send(a, b, q, r, z);
      drain();
   endtask

   initial begin
      int n;
      logic [W-1:0] ra, rb;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",    {31'b0, in_ready},    32'd0);
      chk("rst_out_valid",   {31'b0, out_valid},   32'd0);
      chk("rst_quotient",    quotient,             32'd0);
      chk("rst_remainder",   remainder,            32'd0);
      chk("rst_div_by_zero", {31'b0, div_by_zero}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

      // Directed vectors
      run(16'd100,   16'd7,      16'd14,    16'd2,    1'b0);
      run(16'hFFFF,  16'd1,      16'hFFFF,  16'd0,    1'b0);
      run(16'hFFFF,  16'hFFFF,   16'd1,     16'd0,    1'b0);
      run(16'd3,     16'd10,     16'd0,     16'd3,    1'b0);
      run(16'd0,     16'd5,      16'd0,     16'd0,    1'b0);
      run(16'd5,     16'd0,      16'hFFFF,  16'd5,    1'b1);
      run(16'd8,     16'd2,      16'd4,     16'd0,    1'b0);
      run(16'hFFFF,  16'd0,      16'hFFFF,  16'hFFFF, 1'b1);
      run(16'h8000,  16'd3,      16'd10922, 16'd2,    1'b0);
      run(16'd12345, 16'd123,    16'd100,   16'd45,   1'b0);
      run(16'd1,     16'hFFFF,   16'd0,     16'd1,    1'b0);

      // Back-pressure: results held, in_ready low, stray requests ignored
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0);
      dividend = 16'd7;
      divisor  = 16'd1;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
         @(negedge clk);
         n++;
      end
      chk("hold_reached_done", {31'b0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("hold_out_valid", {31'b0, out_valid},   32'd1);
         chk("hold_quotient",  quotient,             32'd30);
         chk("hold_remainder", remainder,            32'd10);
         chk("hold_dbz",       {31'b0, div_by_zero}, 32'd0);
         chk("done_in_ready",  {31'b0, in_ready},    32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      @(negedge clk);
      chk("after_hold_out_valid", {31'b0, out_valid}, 32'd0);

      // Reset on the 8th BUSY edge aborts the operation
      send(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sb.delete();
      chk("abort_out_valid",   {31'b0, out_valid},   32'd0);
      chk("abort_quotient",    quotient,             32'd0);
      chk("abort_remainder",   remainder,            32'd0);
      chk("abort_div_by_zero", {31'b0, div_by_zero}, 32'd0);
      chk("abort_in_ready",    {31'b0, in_ready},    32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_abort_in_ready", {31'b0, in_ready}, 32'd1);
      run(16'd9, 16'd4, 16'd2, 16'd1, 1'b0);

      // Short random sweep against a behavioural reference
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         case (i % 4)
            0:       rb = '0;
            1:       rb = 16'd1;
            2:       rb = 16'hFFFF;
            default: rb = W'($urandom_range(1, 300));
         endcase
         if (rb == '0) run(ra, rb, 16'hFFFF, ra, 1'b1);
         else          run(ra, rb, ra / rb, ra % rb, 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
